// File: rtl/mlu_muldiv_seq_pkg.sv
// Shared types for the iterative multiply/divide sequencer and its MLU hookup.
// Holds the function select, MLU opcodes, iteration count and step helpers.
// No logic of its own; imported by the interface, the counter and the top.
package mlu_muldiv_seq_pkg;

  // Function select presented with START
  typedef enum logic {
    MULDIV_MULU = 1'b0,
    MULDIV_DIVU = 1'b1
  } muldiv_fn_t;

  // One iteration per operand bit; tied to the MLU width
  localparam int MULDIV_ITERS = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_ITERS);

  // MLU opcodes; ADD/SUB are the only ones this block issues
  typedef enum logic [2:0] {
    MLU_NOP0 = 3'd0,
    MLU_ADD  = 3'd1,
    MLU_SUB  = 3'd2,
    MLU_AND  = 3'd3,
    MLU_OR   = 3'd4,
    MLU_XOR  = 3'd5,
    MLU_NOP6 = 3'd6,
    MLU_NOP7 = 3'd7
  } mlu_op_t;

  // 64-bit HI:LO accumulator
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } muldiv_acc_t;

  // Shift-and-add step: {carry, sum, LO} shifted right by one, LSB dropped
  function automatic muldiv_acc_t mul_step(input logic c, input logic [31:0] sum,
                                           input logic [31:0] lo);
    muldiv_acc_t r;
    r.hi = {c, sum[31:1]};
    r.lo = {sum[0], lo[31:1]};
    return r;
  endfunction

  // Restoring-division step: keep the difference when the shifted remainder >= divisor
  function automatic muldiv_acc_t div_step(input logic ge, input logic [31:0] diff,
                                           input logic [31:0] s, input logic [31:0] lo);
    muldiv_acc_t r;
    r.hi = ge ? diff : s;
    r.lo = {lo[30:0], ge};
    return r;
  endfunction

endpackage

// File: rtl/mlu_muldiv_seq_if.sv
// Request/result handshake plus the borrowed-MLU operand/result bus.
// Purely wiring; no latency of its own.
// START is only honoured by the sequencer while it is idle; no backpressure.
interface mlu_muldiv_seq_if;
  import mlu_muldiv_seq_pkg::*;

  // request side
  logic        start;
  muldiv_fn_t  fn;
  logic [31:0] x;
  logic [31:0] y;
  // result side
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  // MLU side
  logic        mlu_own;
  logic [31:0] mlu_a;
  logic [31:0] mlu_b;
  mlu_op_t     mlu_op;
  logic        mlu_c_in;
  logic [31:0] mlu_out;
  logic        mlu_c;

  // Register file / datapath side: issues requests and returns MLU results
  modport master (
    output start, fn, x, y, mlu_out, mlu_c,
    input  busy, done, div_zero, res_lo, res_hi,
    input  mlu_own, mlu_a, mlu_b, mlu_op, mlu_c_in
  );

  // Sequencer side
  modport slave (
    input  start, fn, x, y, mlu_out, mlu_c,
    output busy, done, div_zero, res_lo, res_hi,
    output mlu_own, mlu_a, mlu_b, mlu_op, mlu_c_in
  );

endinterface

// File: rtl/mlu_muldiv_seq_iter_counter.sv
// Iteration counter for the mul/div sequencer: clear, enable, terminal count.
// TC is combinational from the registered count (flags the last iteration).
// No handshake; counts whenever EN is high, CLR has priority.
module muldiv_iter_counter
  import mlu_muldiv_seq_pkg::*;
#(
  parameter int ITERS = MULDIV_ITERS
) (
  input  logic i_clk,
  input  logic i_n_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] TC_VAL = CW'(ITERS - 1);

  logic [CW-1:0] r_count;

  // Count iterations; reset and clear both return to zero
  always_ff @(posedge i_clk) begin
    if (i_n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mlu_muldiv_seq.sv
// Iterative 32-bit unsigned MULU/DIVU sequencer driving the shared MLU one step per cycle.
// Latency: DONE 33 cycles after START acceptance; divide-by-zero finishes in 1 cycle.
// START is sampled only in IDLE; requests while busy or done are dropped, not queued.
module mlu_muldiv_seq
  import mlu_muldiv_seq_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_n_rst,
  mlu_muldiv_seq_if.slave     io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_m;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;
  logic        r_mlu_own;

  logic        w_accept;
  logic        w_cnt_en;
  logic        w_cnt_tc;
  logic [31:0] w_div_s;
  logic        w_div_ge;
  muldiv_acc_t w_acc_nxt;
  logic [31:0] w_mlu_a;
  logic [31:0] w_mlu_b;
  mlu_op_t     w_mlu_op;
  logic        w_mlu_c_in;

  assign w_accept = (r_state == ST_IDLE) && io_bus.start;
  assign w_cnt_en = (r_state == ST_MUL) || (r_state == ST_DIV);

  muldiv_iter_counter #(
    .ITERS (MULDIV_ITERS)
  ) u_iter_cnt (
    .i_clk   (i_clk),
    .i_n_rst (i_n_rst),
    .i_clr   (w_accept),
    .i_en    (w_cnt_en),
    .o_tc    (w_cnt_tc)
  );

  // Shifted partial remainder and its ">= divisor" decision; bit T covers the 33rd bit
  assign w_div_s  = {r_hi[30:0], r_lo[31]};
  assign w_div_ge = r_hi[31] | io_bus.mlu_c;

  // Drive the MLU from the current accumulator; idle/done park it on NOP0 with zero operands
  always_comb begin
    w_mlu_a    = '0;
    w_mlu_b    = '0;
    w_mlu_op   = MLU_NOP0;
    w_mlu_c_in = 1'b0;
    case (r_state)
      ST_MUL: begin
        w_mlu_a  = r_hi;
        w_mlu_b  = r_lo[0] ? r_m : '0;
        w_mlu_op = MLU_ADD;
      end
      ST_DIV: begin
        w_mlu_a    = w_div_s;
        w_mlu_b    = r_m;
        w_mlu_op   = MLU_SUB;
        w_mlu_c_in = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next accumulator value from this cycle's MLU result
  always_comb begin
    w_acc_nxt = '{hi: r_hi, lo: r_lo};
    if (r_state == ST_MUL) begin
      w_acc_nxt = mul_step(io_bus.mlu_c, io_bus.mlu_out, r_lo);
    end else if (r_state == ST_DIV) begin
      w_acc_nxt = div_step(w_div_ge, io_bus.mlu_out, w_div_s, r_lo);
    end
  end

  // Sequencer FSM with accumulator, result and status registers
  always_ff @(posedge i_clk) begin
    if (i_n_rst) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_m        <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_mlu_own  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_div_zero <= 1'b0;
            if (io_bus.fn == MULDIV_MULU || io_bus.y != '0) begin
              r_hi      <= '0;
              r_lo      <= io_bus.x;
              r_m       <= io_bus.y;
              r_busy    <= 1'b1;
              r_mlu_own <= 1'b1;
              r_state   <= (io_bus.fn == MULDIV_MULU) ? ST_MUL : ST_DIV;
            end else begin
              // Divide by zero: all-ones quotient, dividend as remainder, MLU untouched
              r_res_lo   <= '1;
              r_res_hi   <= io_bus.x;
              r_div_zero <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          r_hi <= w_acc_nxt.hi;
          r_lo <= w_acc_nxt.lo;
          if (w_cnt_tc) begin
            r_res_hi  <= w_acc_nxt.hi;
            r_res_lo  <= w_acc_nxt.lo;
            r_busy    <= 1'b0;
            r_mlu_own <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.div_zero = r_div_zero;
  assign io_bus.res_lo   = r_res_lo;
  assign io_bus.res_hi   = r_res_hi;
  assign io_bus.mlu_own  = r_mlu_own;
  assign io_bus.mlu_a    = w_mlu_a;
  assign io_bus.mlu_b    = w_mlu_b;
  assign io_bus.mlu_op   = w_mlu_op;
  assign io_bus.mlu_c_in = w_mlu_c_in;

endmodule

// File: tb/tb_mlu_muldiv_seq.sv
// Bench for mlu_muldiv_seq with a behavioural MLU and a scoreboard of expected results.
// Expected values come from plain 64-bit multiply, / and %.
// A negedge monitor pops the scoreboard on every DONE pulse.
module tb_mlu_muldiv_seq;
  import mlu_muldiv_seq_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  mlu_muldiv_seq_if bus ();

  mlu_muldiv_seq dut (
    .i_clk   (clk),
    .i_n_rst (n_rst),
    .io_bus  (bus)
  );

  // Behavioural MLU: add with carry, subtract as A + ~B + C_IN (carry = no borrow)
  always_comb begin
    bus.mlu_out = '0;
    bus.mlu_c   = 1'b0;
    case (bus.mlu_op)
      MLU_ADD: {bus.mlu_c, bus.mlu_out} = {1'b0, bus.mlu_a} + {1'b0, bus.mlu_b} + {32'b0, bus.mlu_c_in};
      MLU_SUB: {bus.mlu_c, bus.mlu_out} = {1'b0, bus.mlu_a} + {1'b0, ~bus.mlu_b} + {32'b0, bus.mlu_c_in};
      default: begin
      end
    endcase
  end

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every DONE pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got DONE with empty scoreboard want none");
      end else begin
        mon_e = sb_q.pop_front();
        chk("res_hi", 64'(bus.res_hi), 64'(mon_e.hi));
        chk("res_lo", 64'(bus.res_lo), 64'(mon_e.lo));
        chk("div_zero", 64'(bus.div_zero), 64'(mon_e.dz));
      end
    end
  end

  // Issue one operation (called at a negedge with the DUT idle) and follow it to DONE
  task automatic do_op(input muldiv_fn_t fn, input logic [31:0] x, input logic [31:0] y,
                       input bit noise);
    exp_t        e;
    logic [63:0] p;
    bit          dz;
    bit          seen;
    bit          exp_busy;
    int          lat;
    int          cyc;
    int          busy_err;
    int          own_err;
    dz = (fn == MULDIV_DIVU) && (y == 32'd0);
    if (fn == MULDIV_MULU) begin
      p    = {32'b0, x} * {32'b0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (dz) begin
      e.hi = x;
      e.lo = 32'hFFFF_FFFF;
    end else begin
      e.hi = x % y;
      e.lo = x / y;
    end
    e.dz = dz;
    sb_q.push_back(e);
    lat = dz ? 1 : 33;

    bus.start = 1'b1;
    bus.fn    = fn;
    bus.x     = x;
    bus.y     = y;
    @(posedge clk);
    cyc      = 0;
    seen     = 1'b0;
    busy_err = 0;
    own_err  = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.x     = $urandom;
        bus.y     = $urandom;
        bus.fn    = muldiv_fn_t'(1'($urandom_range(0, 1)));
        chk("dz_clear_on_start", 64'(bus.div_zero), 64'(dz));
      end
      if (!dz && cyc == 16) begin
        chk("res_hold_hi", 64'(bus.res_hi), 64'(prev_hi));
        chk("res_hold_lo", 64'(bus.res_lo), 64'(prev_lo));
      end
      if (noise && (cyc == 5 || cyc == 31)) bus.start = 1'b1;
      if (noise && cyc == 6) bus.start = 1'b0;
      exp_busy = !dz && (cyc <= 32);
      if (bus.busy !== exp_busy) busy_err++;
      if (bus.mlu_own !== exp_busy) own_err++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("busy_profile_errs", 64'(busy_err), 64'd0);
    chk("mlu_own_profile_errs", 64'(own_err), 64'd0);
    prev_hi = e.hi;
    prev_lo = e.lo;
    @(negedge clk);
    if (noise) begin
      bus.start = 1'b0;
      chk("start_ignored_busy", 64'(bus.busy), 64'd0);
      chk("start_ignored_done", 64'(bus.done), 64'd0);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    muldiv_fn_t  rf;
    int          sel;
    bus.start = 1'b1;
    bus.fn    = MULDIV_DIVU;
    bus.x     = 32'hDEAD_BEEF;
    bus.y     = 32'd0;

    // Reset state with garbage on the request inputs
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    chk("rst_mlu_own", 64'(bus.mlu_own), 64'd0);
    chk("rst_res_lo", 64'(bus.res_lo), 64'd0);
    chk("rst_res_hi", 64'(bus.res_hi), 64'd0);
    chk("rst_mlu_op", 64'(bus.mlu_op), 64'(MLU_NOP0));
    n_rst     = 1'b0;
    bus.start = 1'b0;

    // Directed cases; the first START lands on the first edge out of reset
    do_op(MULDIV_MULU, 32'd7, 32'd6, 1'b0);
    do_op(MULDIV_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(MULDIV_DIVU, 32'd100, 32'd7, 1'b0);
    do_op(MULDIV_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op(MULDIV_DIVU, 32'd5, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("dz_held", 64'(bus.div_zero), 64'd1);
    chk("dz_res_held", 64'(bus.res_lo), 64'hFFFF_FFFF);

    // Reset in the middle of MULU 3*4: operation discarded, outputs cleared
    bus.start = 1'b1;
    bus.fn    = MULDIV_MULU;
    bus.x     = 32'd3;
    bus.y     = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_mlu_own", 64'(bus.mlu_own), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_res", {bus.res_hi, bus.res_lo}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    do_op(MULDIV_MULU, 32'd3, 32'd5, 1'b1);

    // Randomized operations, with occasional zero/small/near-equal divisors
    for (int i = 0; i < 40; i++) begin
      rf  = muldiv_fn_t'(1'($urandom_range(0, 1)));
      rx  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'd0;
      else if (sel == 1) ry = 32'($urandom_range(1, 15));
      else if (sel == 2) ry = rx - 32'($urandom_range(0, 3));
      else ry = $urandom;
      do_op(rf, rx, ry, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
